// File: rtl/sam_mem_pkg.sv
// Shared defaults, FSM state encoding and the fill byte for the SAM memory unit.
package sam_mem_pkg;

    localparam int DEPTH_DEF = 64;
    localparam int WIDTH_DEF = 8;

    // state | meaning
    // IDLE  | CPU owns the memory; loader waits for ldStart
    // LOAD  | loader bytes accepted on ldValid, CPU paused
    // FILL  | zero-fill from ldAddr up to the last address
    // DONE  | single-cycle loadDone pulse, then back to IDLE
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FILL = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [7:0] FILL_BYTE = 8'h00;

endpackage

// File: rtl/sam_ram_64x8.sv
// Storage array: one synchronous write port and one registered read port, no array reset.
module sam_ram_64x8
    import sam_mem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic             re,
    input  logic [AW-1:0]    ra,
    output logic [WIDTH-1:0] rd
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[wa] <= wd;
        end
        if (re) begin
            r_rd <= r_mem[ra];
        end
    end

    assign rd = r_rd;

endmodule

// File: rtl/sam_memory_unit.sv
// CPU-facing 64x8 memory with a byte-stream program loader that pauses the CPU,
// writes the image and zero-fills the unloaded tail.
module sam_memory_unit
    import sam_mem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             rw,
    input  logic [WIDTH-1:0] aBus,
    input  logic [WIDTH-1:0] dBusIn,
    output logic [WIDTH-1:0] dBusOut,
    input  logic             ldStart,
    input  logic             ldValid,
    input  logic [WIDTH-1:0] ldData,
    input  logic             ldEnd,
    output logic             ldReady,
    output logic             cpuHold,
    output logic             loadDone,
    output logic             addrErr
);

    localparam int            AW        = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [WIDTH:0] DEPTH_W  = (WIDTH + 1)'(DEPTH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [AW-1:0]    r_ld_addr;
    logic             r_addr_err;
    logic             r_rd_zero;

    logic             w_idle;
    logic             w_oor;
    logic             w_cpu_acc;
    logic             w_cpu_rd;
    logic             w_cpu_wr;
    logic             w_ld_last;
    logic             w_ld_step;
    logic             w_we;
    logic [AW-1:0]    w_wa;
    logic [WIDTH-1:0] w_wd;
    logic [WIDTH-1:0] w_ram_rd;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_oor     = ({1'b0, aBus} >= DEPTH_W);
    assign w_cpu_acc = w_idle & en;
    assign w_cpu_rd  = w_cpu_acc & rw;
    assign w_cpu_wr  = w_cpu_acc & ~rw & ~w_oor;
    assign w_ld_last = (r_ld_addr == LAST_ADDR);
    // Terminal address is checked before incrementing so ldAddr never wraps.
    assign w_ld_step = (((r_state == ST_LOAD) & ldValid) | (r_state == ST_FILL)) & ~w_ld_last;

    always_comb begin
        w_state_nxt = r_state;
        w_we        = w_cpu_wr;
        w_wa        = aBus[AW-1:0];
        w_wd        = dBusIn;
        case (r_state)
            ST_IDLE: begin
                if (ldStart) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (ldValid) begin
                    w_we = 1'b1;
                    w_wa = r_ld_addr;
                    w_wd = ldData;
                    if (w_ld_last) begin
                        w_state_nxt = ST_DONE;
                    end else if (ldEnd) begin
                        w_state_nxt = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                w_we = 1'b1;
                w_wa = r_ld_addr;
                w_wd = WIDTH'(FILL_BYTE);
                if (w_ld_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // r_rd_zero masks the RAM read register after reset and after out-of-range reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ld_addr  <= '0;
            r_addr_err <= 1'b0;
            r_rd_zero  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (w_idle & ldStart) begin
                r_ld_addr <= '0;
            end else if (w_ld_step) begin
                r_ld_addr <= r_ld_addr + 1'b1;
            end
            if (w_cpu_acc & w_oor) begin
                r_addr_err <= 1'b1;
            end
            if (w_cpu_rd) begin
                r_rd_zero <= w_oor;
            end
        end
    end

    sam_ram_64x8 #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_ram (
        .clk (clk),
        .we  (w_we),
        .wa  (w_wa),
        .wd  (w_wd),
        .re  (w_cpu_rd & ~w_oor),
        .ra  (aBus[AW-1:0]),
        .rd  (w_ram_rd)
    );

    assign dBusOut  = r_rd_zero ? '0 : w_ram_rd;
    assign ldReady  = (r_state == ST_LOAD);
    assign cpuHold  = ~w_idle;
    assign loadDone = (r_state == ST_DONE);
    assign addrErr  = r_addr_err;

endmodule

// File: tb/tb_sam_memory_unit.sv
// Directed bench for sam_memory_unit: CPU access, full/short/gapped loads, hold and reset behaviour.
module tb_sam_memory_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       rw;
    logic [7:0] aBus;
    logic [7:0] dBusIn;
    logic [7:0] dBusOut;
    logic       ldStart;
    logic       ldValid;
    logic [7:0] ldData;
    logic       ldEnd;
    logic       ldReady;
    logic       cpuHold;
    logic       loadDone;
    logic       addrErr;

    int n_checks = 0;
    int n_errors = 0;
    int hold_cnt = 0;
    int done_cnt = 0;

    sam_memory_unit #(.DEPTH(64), .WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .rw       (rw),
        .aBus     (aBus),
        .dBusIn   (dBusIn),
        .dBusOut  (dBusOut),
        .ldStart  (ldStart),
        .ldValid  (ldValid),
        .ldData   (ldData),
        .ldEnd    (ldEnd),
        .ldReady  (ldReady),
        .cpuHold  (cpuHold),
        .loadDone (loadDone),
        .addrErr  (addrErr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cpuHold)  hold_cnt++;
        if (loadDone) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        en = 1'b1; rw = 1'b0; aBus = a; dBusIn = d;
        tick();
        en = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
        en = 1'b1; rw = 1'b1; aBus = a;
        tick();
        en = 1'b0;
        check(tag, dBusOut, exp);
    endtask

    // ldStart pulse followed by one LOAD entry cycle before the first byte
    task automatic start_load;
        ldStart = 1'b1;
        tick();
        ldStart = 1'b0;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        ldValid = 1'b1; ldData = d; ldEnd = last;
        tick();
        ldValid = 1'b0; ldEnd = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!loadDone && n < 200) begin
            tick();
            n++;
        end
        check("done_timeout", (n < 200), 1);
        tick();
    endtask

    initial begin
        int n;
        int h0;
        int d0;
        rst = 1'b1; en = 1'b0; rw = 1'b0; aBus = '0; dBusIn = '0;
        ldStart = 1'b0; ldValid = 1'b0; ldData = '0; ldEnd = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // 1: reset values and basic CPU write/read
        check("rst_dbus", dBusOut, 8'h00);
        check("rst_ready", ldReady, 0);
        check("rst_hold", cpuHold, 0);
        check("rst_done", loadDone, 0);
        check("rst_err", addrErr, 0);
        cpu_write(8'd1, 8'h61);
        rd_chk("rd_a1", 8'd1, 8'h61);
        check("err_after_rw", addrErr, 0);

        // 2: full back-to-back load, data = addr ^ A5
        h0 = hold_cnt; d0 = done_cnt;
        start_load();
        check("load_ready", ldReady, 1);
        for (int i = 0; i < 64; i++) begin
            send_byte(8'(i) ^ 8'hA5, (i == 63));
        end
        check("full_ready_drop", ldReady, 0);
        check("full_done_pulse", loadDone, 1);
        tick();
        tick();
        check("full_hold_cycles", hold_cnt - h0, 66);
        check("full_done_count", done_cnt - d0, 1);
        rd_chk("full_a19", 8'd19, 8'hB6);
        rd_chk("full_a0", 8'd0, 8'hA5);
        rd_chk("full_a63", 8'd63, 8'h9A);

        // 3: short load, ldEnd on byte 2, then zero fill
        start_load();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b1);
        check("fill_ready", ldReady, 0);
        check("fill_hold", cpuHold, 1);
        wait_done(n);
        check("fill_cycles", n, 61);
        rd_chk("short_a0", 8'd0, 8'h11);
        rd_chk("short_a1", 8'd1, 8'h22);
        rd_chk("short_a2", 8'd2, 8'h33);
        for (int a = 3; a < 64; a++) begin
            rd_chk($sformatf("fill_a%0d", a), 8'(a), 8'h00);
        end

        // 4: gapped loader, junk data on idle cycles
        start_load();
        for (int i = 0; i < 8; i++) begin
            send_byte(8'(i * 3 + 8'h40), (i == 7));
            if (i < 7) begin
                ldData = 8'hEE;
                tick();
            end
        end
        wait_done(n);
        check("gap_fill_cycles", n, 56);
        for (int i = 0; i < 8; i++) begin
            rd_chk($sformatf("gap_a%0d", i), 8'(i), 8'(i * 3 + 8'h40));
        end
        rd_chk("gap_a8", 8'd8, 8'h00);

        // 5: CPU accesses and ldStart during LOAD are ignored
        rd_chk("pre5_a0", 8'd0, 8'h40);
        start_load();
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin en = 1'b1; rw = 1'b0; aBus = 8'd5; dBusIn = 8'hFF; end
            if (i == 4) ldStart = 1'b1;
            if (i == 5) begin en = 1'b1; rw = 1'b1; aBus = 8'd1; end
            send_byte(8'(8'h80 + i), (i == 9));
            en = 1'b0; ldStart = 1'b0;
            if (i == 5) check("hold_dbus", dBusOut, 8'h40);
        end
        wait_done(n);
        check("h5_fill_cycles", n, 54);
        rd_chk("h5_a5", 8'd5, 8'h85);
        rd_chk("h5_a0", 8'd0, 8'h80);
        rd_chk("h5_a9", 8'd9, 8'h89);
        rd_chk("h5_a10", 8'd10, 8'h00);
        check("h5_err", addrErr, 0);

        // 6: out-of-range accesses, then reset mid-load
        rd_chk("pre6_a0", 8'd0, 8'h80);
        rd_chk("oor_64", 8'd64, 8'h00);
        check("oor_err_set", addrErr, 1);
        rd_chk("oor_70", 8'd70, 8'h00);
        cpu_write(8'd70, 8'h5A);
        rd_chk("oor_no_alias", 8'd6, 8'h86);
        check("oor_err_sticky", addrErr, 1);
        d0 = done_cnt;
        start_load();
        for (int i = 0; i < 10; i++) begin
            send_byte(8'(8'hC0 + i), 1'b0);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_hold", cpuHold, 0);
        check("mid_rst_ready", ldReady, 0);
        check("mid_rst_err", addrErr, 0);
        check("mid_rst_dbus", dBusOut, 8'h00);
        tick();
        tick();
        check("mid_rst_no_done", done_cnt - d0, 0);
        for (int i = 0; i < 10; i++) begin
            rd_chk($sformatf("rst_keep_a%0d", i), 8'(i), 8'(8'hC0 + i));
        end
        rd_chk("rst_keep_a10", 8'd10, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sam_memory_unit.md
# sam_memory_unit

Synthesizable 64x8 program/data memory that sits directly downstream of the Very_Half_SAM CPU bus and answers its `en`/`rw`/`aBus` requests with one-cycle registered reads. It also contains a byte-stream program loader. The loader holds the CPU in pause, writes an image into memory with a valid/ready handshake, and zero-fills any unloaded tail. This block replaces the behavioural memory array for FPGA builds.

## Interface
Parameters:
- `DEPTH`, 64: number of words; addresses `0..DEPTH-1`.
- `WIDTH`, 8: data and address width.

Ports:
- `clk`, in, 1: single clock; all state changes on rising edge.
- `rst`, in, 1: reset. Synchronous and active-high.
- `en`, in, 1: CPU access enable.
- `rw`, in, 1: 1 = read, 0 = write (qualified by `en`).
- `aBus`, in, 8: CPU address.
- `dBusIn`, in, 8: CPU write data.
- `dBusOut`, out, 8: registered read data to the CPU.
- `ldStart`, in, 1: one-cycle request to begin a load (honoured only in IDLE).
- `ldValid`, in, 1: loader byte valid.
- `ldData`, in, 8: loader byte.
- `ldEnd`, in, 1: last byte marker (qualified by `ldValid`).
- `ldReady`, out, 1: block accepts a loader byte this cycle.
- `cpuHold`, out, 1: drives the CPU `pause` input; high whenever the state is not IDLE.
- `loadDone`, out, 1: one-cycle pulse when a load completes.
- `addrErr`, out, 1: sticky flag; set by a CPU access to an address >= `DEPTH`.

## Operation
- **States:** IDLE, LOAD, FILL, DONE.
- **IDLE, CPU side:**
  - `en & rw`: `dBusOut <= mem[aBus]`.
  - `en & ~rw`: `mem[aBus] <= dBusIn`.
  - `~en`: `dBusOut` holds its value.
- **Out-of-range CPU access** (`aBus >= DEPTH`):
  - Read returns `8'h00`.
  - Write is dropped.
  - `addrErr <= 1` in either case; cleared only by `rst`.
- **IDLE to LOAD:** `ldStart` moves to LOAD and sets `ldAddr <= 0`. `ldStart` in any other state is ignored.
- **LOAD:**
  - `ldReady = 1`.
  - On `ldValid`: `mem[ldAddr] <= ldData`, then `ldAddr++`.
  - If the byte was at `ldAddr == DEPTH-1`, go to DONE. This applies regardless of `ldEnd`.
  - Else if `ldEnd`, go to FILL. FILL starts at the next address.
  - Further bytes beyond `DEPTH` are never accepted.
- **FILL:**
  - `ldReady = 0`.
  - Writes `8'h00` to `mem[ldAddr]`, one address per cycle, with `ldAddr++`.
  - After writing `DEPTH-1`, go to DONE.
- **DONE:** one cycle with `loadDone = 1`, then IDLE.
- **CPU requests while not IDLE** are ignored: no write, `dBusOut` holds, and `addrErr` is not updated.
- **`ldAddr` width:** `$clog2(DEPTH)` bits. It must not wrap during LOAD or FILL; the terminal-address check precedes the increment.

## Timing
- **Reset values:**
  - State is IDLE.
  - `dBusOut`, `ldReady`, `cpuHold`, `loadDone` and `addrErr` are all 0.
  - `ldAddr` is 0.
  - Memory contents are not cleared.
- **Read latency:** 1 cycle. `aBus` is sampled at edge N, and `dBusOut` is valid after edge N and held until the next read.
- **Write:** takes effect at the sampling edge. A read of the same address on the next cycle returns the new value.
- **`cpuHold` and `ldReady`:** both are Moore outputs of the state register.
  - `cpuHold` rises the cycle after `ldStart` is sampled.
  - `cpuHold` falls the cycle after DONE.
- **Handshake:** a byte transfers on a rising edge where `ldValid & ldReady`. The source may hold `ldValid` high continuously for back-to-back bytes.
- **Full load:** a 64-byte load with no gaps spans 1 (LOAD entry) + 64 (bytes) + 1 (DONE) cycles of `cpuHold`.
- **`ldEnd` on byte k (0-based, k < DEPTH-1):** FILL lasts `DEPTH-1-k` cycles.
- **Reset mid-load:** immediate return to IDLE. Bytes already written remain, and `loadDone` is not pulsed.

## Structure
- **Package `sam_mem_pkg`:**
  - Defaults for `DEPTH` and `WIDTH`.
  - The state enum (IDLE/LOAD/FILL/DONE).
  - The fill constant `8'h00`.
- **Sub-module `sam_ram_64x8`:** the storage array with one synchronous write port (`we`, `wa`, `wd`) and one synchronous registered read port (`re`, `ra`, `rd`). It has no reset on the array.
- **Top level:** owns the FSM, the write-port mux (CPU vs loader vs fill), the range check and the flags.

## Test plan
1. **Reset, then CPU writes and reads:** write `8'h61` to addr 1, then read addr 1. Expect `dBusOut = 8'h61` one cycle after the read is sampled. `addrErr = 0`.
2. **Full 64-byte back-to-back load** (bytes = address XOR `8'hA5`):
   - `cpuHold` is high for 66 cycles.
   - `ldReady` drops after byte 63.
   - A single `loadDone` pulse occurs.
   - CPU readback of addr 19 = `8'hB6`.
3. **Short load of 3 bytes** with `ldEnd` on byte 2:
   - Addresses 0-2 hold the loaded data.
   - FILL lasts 61 cycles.
   - Addresses 3-63 read `8'h00`.
4. **Gapped loader:** `ldValid` toggles every other cycle. Each byte is written exactly once, and the data is correct.
5. **CPU access while `cpuHold` = 1:** a CPU write of `8'hFF` to addr 5 during LOAD is dropped. After the load, addr 5 holds the loaded value. `ldStart` re-pulsed during LOAD is ignored.
6. **Out-of-range read at `aBus = 8'd70`:**
   - Returns `8'h00` and sets `addrErr`.
   - Then assert `rst` mid-load after 10 bytes: state is IDLE, `addrErr = 0`, addresses 0-9 keep the loaded data, and no `loadDone` pulse occurs.
